hardcopyii_muxn_reg: RTL and testbench
======================================

Name: hardcopyii_muxn_reg

Overview:
- Parametrised, registered N:1 multiplexer. It is the next generation of the combinational 4:1 mux atom in the HardCopy II primitive library.
- Generalised in data width and channel count, with a configurable 1- or 2-cycle pipeline, clock enable, valid tagging, a round-robin scan mode driven by an internal channel counter, and out-of-range select detection.
- Used wherever a time-multiplexed, retimed channel selector is needed, for example debug/observation muxes and serialisers feeding narrow datapaths.

Parameters:
- WIDTH, 1: data bits per channel (1..64).
- NUM_IN, 4: number of input channels (2..64); need not be a power of two.
- SEL_W, 2: select/counter width; must satisfy 2**SEL_W >= NUM_IN.
- LATENCY, 1: pipeline depth, 1 or 2 cycles from accepted input to MO. Any other value is a compile-time error.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- SCLR  input  1  reset, synchronous, active-high; overrides ENA.
- ENA  input  1  clock enable; 0 freezes all state (pipeline, counter, flags).
- IN  input  NUM_IN*WIDTH  channel data; channel k occupies IN[k*WIDTH +: WIDTH].
- IN_VALID  input  1  qualifies the current IN/S sample.
- S  input  SEL_W  external channel select; used when SCAN=0.
- SCAN  input  1  1 = internal counter selects the channel; 0 = S selects.
- MO  output  WIDTH  selected data, registered.
- MO_VALID  output  1  MO carries an accepted sample.
- MO_CH  output  SEL_W  channel index that produced MO.
- SEL_ERR  output  1  the sample now on MO used an out-of-range select.

Behaviour:
- Reset (SCLR=1 at a clock edge): MO=0, MO_VALID=0, MO_CH=0, SEL_ERR=0, scan counter=0, all internal pipeline registers and valids cleared. Reset mid-stream discards all in-flight samples; MO_VALID stays 0 until LATENCY edges after the first post-reset accept.
- Accept: a sample is accepted on a rising edge with SCLR=0, ENA=1, IN_VALID=1.
- Effective select: sel = SCAN ? cnt : S, sampled at the accept edge together with IN.
- LATENCY=1: at the accept edge, MO/MO_CH/SEL_ERR/MO_VALID load directly.
  - MO = IN channel sel.
  - MO_CH = sel.
  - SEL_ERR = (sel >= NUM_IN).
  - MO_VALID = 1.
- LATENCY=2:
  - Stage 1 registers IN (full bus), sel and a valid bit.
  - Stage 2 performs the mux into MO on the next ENA=1 edge.
  - A sample accepted at edge t appears at edge t+1 with no stalls.
- Non-accept edge (ENA=1, IN_VALID=0): a bubble propagates. MO_VALID=0 when the bubble reaches the output; MO, MO_CH and SEL_ERR hold their previous values.
- ENA=0: every register holds, including MO_VALID. The pipeline stretches, and no sample or bubble is lost or duplicated.
- Out-of-range sel (NUM_IN <= sel < 2**SEL_W): MO=0, SEL_ERR=1, MO_VALID=1, MO_CH=sel. SEL_ERR is per-sample, not sticky.
- Scan counter cnt:
  - Advances only on an accept edge with SCAN=1.
  - Sequence is 0,1,...,NUM_IN-1,0 (wraps at NUM_IN, not at 2**SEL_W), so it never produces SEL_ERR.
  - The value used for a sample is the pre-increment value.
- SCAN=0: cnt holds its value. Re-entering SCAN resumes from the held cnt; there is no implicit restart. Only SCLR resets cnt.
- SCAN is sampled per accept edge. Toggling SCAN between consecutive accepts is legal; each sample uses the mode present at its own edge.
- Simultaneous events: SCLR beats ENA/IN_VALID. Accept and counter wrap in the same edge are normal; sample uses NUM_IN-1, cnt becomes 0.
- Purely synchronous; no combinational path from any input to any output.

Test Plan:
- Reset/basic (WIDTH=8, NUM_IN=4, LATENCY=1):
  - Stimulus: SCLR 2 cycles, then IN={8'h44,8'h33,8'h22,8'h11}, S=2, IN_VALID=1.
  - Response: outputs are 0 during reset; one edge later MO=8'h33, MO_CH=2, MO_VALID=1, SEL_ERR=0.
- Scan wrap (NUM_IN=3, SEL_W=2, LATENCY=2):
  - Stimulus: SCAN=1, IN_VALID=1 for 7 cycles, channel data 8'hA0/8'hA1/8'hA2.
  - Response: MO_CH sequence 0,1,2,0,1,2,0 starting 2 edges after the first accept; SEL_ERR never set.
- Out-of-range (NUM_IN=3):
  - Stimulus: SCAN=0, S=3, IN_VALID=1.
  - Response: MO=0, SEL_ERR=1, MO_VALID=1, MO_CH=3. Next sample with S=1 gives SEL_ERR=0.
- Stall/bubble (LATENCY=2):
  - Stimulus: accepts with S=0,1; ENA=0 for 3 cycles between them; then IN_VALID=0 for 1 cycle.
  - Response: both samples emerge in order with no duplicates; MO held during the stall; one MO_VALID=0 cycle with MO unchanged.
- Reset mid-operation:
  - Stimulus: SCLR asserted while 2 samples are in flight (LATENCY=2) and cnt=2.
  - Response: no stale MO_VALID after reset; cnt restarts at 0 (first scan sample MO_CH=0).
- Mode switch:
  - Stimulus: SCAN=1 for 2 accepts (cnt 0→2), SCAN=0 with S=3 for 1 accept, SCAN=1 again.
  - Response: MO_CH sequence 0,1,3,2.

Source files
------------

// File: rtl/hardcopyii_muxn_reg_if.sv
// Bus bundle for the registered N:1 channel mux.
// The master drives the channel data, select and qualifiers; the slave returns the registered output.
interface hardcopyii_muxn_reg_if #(
    parameter int WIDTH  = 1,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
);
    logic                    ENA;
    logic [NUM_IN*WIDTH-1:0] IN;
    logic                    IN_VALID;
    logic [SEL_W-1:0]        S;
    logic                    SCAN;
    logic [WIDTH-1:0]        MO;
    logic                    MO_VALID;
    logic [SEL_W-1:0]        MO_CH;
    logic                    SEL_ERR;

    modport master (
        output ENA, IN, IN_VALID, S, SCAN,
        input  MO, MO_VALID, MO_CH, SEL_ERR
    );

    modport slave (
        input  ENA, IN, IN_VALID, S, SCAN,
        output MO, MO_VALID, MO_CH, SEL_ERR
    );
endinterface

// File: rtl/hardcopyii_muxn_reg.sv
// Registered N:1 multiplexer with 1- or 2-cycle latency, clock enable, valid tagging,
// round-robin scan counter and out-of-range select flagging.
module hardcopyii_muxn_reg #(
    parameter int WIDTH   = 1,
    parameter int NUM_IN  = 4,
    parameter int SEL_W   = 2,
    parameter int LATENCY = 1
) (
    input logic CLK,
    input logic SCLR,
    hardcopyii_muxn_reg_if.slave bus
);
    localparam logic [SEL_W:0]   NUM_IN_EXT = (SEL_W+1)'(NUM_IN);
    localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(NUM_IN - 1);

    if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
        $error("hardcopyii_muxn_reg: LATENCY must be 1 or 2");
    end
    if ((2 ** SEL_W) < NUM_IN) begin : g_bad_sel_w
        $error("hardcopyii_muxn_reg: SEL_W too narrow for NUM_IN");
    end

    logic                    accept;
    logic [SEL_W-1:0]        cnt;
    logic [SEL_W-1:0]        sel_now;
    logic [NUM_IN*WIDTH-1:0] mux_in;
    logic [SEL_W-1:0]        mux_sel;
    logic                    mux_valid;
    logic [WIDTH-1:0]        mux_data;
    logic                    mux_err;

    assign accept  = bus.ENA & bus.IN_VALID;
    assign sel_now = bus.SCAN ? cnt : bus.S;

    // The counter wraps at NUM_IN so scan mode can never select a missing channel.
    always_ff @(posedge CLK) begin
        if (SCLR) begin
            cnt <= '0;
        end else if (accept && bus.SCAN) begin
            cnt <= (cnt == LAST_CH) ? '0 : cnt + SEL_W'(1);
        end
    end

    if (LATENCY == 2) begin : g_stage1
        logic [NUM_IN*WIDTH-1:0] st_in;
        logic [SEL_W-1:0]        st_sel;
        logic                    st_valid;

        always_ff @(posedge CLK) begin
            if (SCLR) begin
                st_in    <= '0;
                st_sel   <= '0;
                st_valid <= 1'b0;
            end else if (bus.ENA) begin
                st_valid <= bus.IN_VALID;
                if (bus.IN_VALID) begin
                    st_in  <= bus.IN;
                    st_sel <= sel_now;
                end
            end
        end

        assign mux_in    = st_in;
        assign mux_sel   = st_sel;
        assign mux_valid = st_valid;
    end else begin : g_direct
        assign mux_in    = bus.IN;
        assign mux_sel   = sel_now;
        assign mux_valid = bus.IN_VALID;
    end

    // Selects beyond the last real channel produce zero data and raise the error tag.
    always_comb begin
        mux_data = '0;
        mux_err  = ({1'b0, mux_sel} >= NUM_IN_EXT);
        for (int k = 0; k < NUM_IN; k++) begin
            if (mux_sel == k[SEL_W-1:0]) begin
                mux_data = mux_in[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (SCLR) begin
            bus.MO       <= '0;
            bus.MO_VALID <= 1'b0;
            bus.MO_CH    <= '0;
            bus.SEL_ERR  <= 1'b0;
        end else if (bus.ENA) begin
            bus.MO_VALID <= mux_valid;
            if (mux_valid) begin
                bus.MO      <= mux_data;
                bus.MO_CH   <= mux_sel;
                bus.SEL_ERR <= mux_err;
            end
        end
    end
endmodule

// File: tb/tb_hardcopyii_muxn_reg.sv
// Bench for hardcopyii_muxn_reg: two instances (4 channels / 1 cycle, 3 channels / 2 cycles)
// driven with the same directed vectors and checked each cycle against a token-level model.
module tb_hardcopyii_muxn_reg;
    logic       CLK = 1'b0;
    logic       sclr = 1'b1;
    logic       ena = 1'b0;
    logic       valid = 1'b0;
    logic [2:0] s = 3'd0;
    logic       scan = 1'b0;
    logic [7:0] chan [0:3];

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 CLK = ~CLK;

    hardcopyii_muxn_reg_if #(.WIDTH(8), .NUM_IN(4), .SEL_W(3)) if_a ();
    hardcopyii_muxn_reg_if #(.WIDTH(8), .NUM_IN(3), .SEL_W(2)) if_b ();

    assign if_a.ENA      = ena;
    assign if_a.IN_VALID = valid;
    assign if_a.S        = s;
    assign if_a.SCAN     = scan;
    assign if_a.IN       = {chan[3], chan[2], chan[1], chan[0]};
    assign if_b.ENA      = ena;
    assign if_b.IN_VALID = valid;
    assign if_b.S        = s[1:0];
    assign if_b.SCAN     = scan;
    assign if_b.IN       = {chan[2], chan[1], chan[0]};

    hardcopyii_muxn_reg #(.WIDTH(8), .NUM_IN(4), .SEL_W(3), .LATENCY(1)) dut_a (
        .CLK (CLK),
        .SCLR(sclr),
        .bus (if_a.slave)
    );

    hardcopyii_muxn_reg #(.WIDTH(8), .NUM_IN(3), .SEL_W(2), .LATENCY(2)) dut_b (
        .CLK (CLK),
        .SCLR(sclr),
        .bus (if_b.slave)
    );

    // Model state: visible output plus one pending token for the 2-cycle instance.
    logic       m_v   [0:1];
    logic [7:0] m_mo  [0:1];
    int         m_ch  [0:1];
    logic       m_err [0:1];
    int         m_cnt [0:1];
    logic       p_v   [0:1];
    logic [7:0] p_d   [0:1];
    int         p_c   [0:1];
    logic       p_e   [0:1];

    task automatic model_apply(input int d, input logic tv, input logic [7:0] td,
                               input int tc, input logic te);
        m_v[d] = tv;
        if (tv) begin
            m_mo[d]  = td;
            m_ch[d]  = tc;
            m_err[d] = te;
        end
    endtask

    task automatic model_edge(input int d, input int n, input int lat, input int selw);
        int         sel;
        logic       nv;
        logic [7:0] nd;
        int         nc;
        logic       ne;
        if (sclr) begin
            m_v[d] = 1'b0; m_mo[d] = 8'h00; m_ch[d] = 0; m_err[d] = 1'b0;
            m_cnt[d] = 0;  p_v[d] = 1'b0;   p_d[d] = 8'h00; p_c[d] = 0; p_e[d] = 1'b0;
        end else if (ena) begin
            nv = valid; nd = 8'h00; nc = 0; ne = 1'b0;
            if (valid) begin
                sel = scan ? m_cnt[d] : (int'(s) % (1 << selw));
                ne  = (sel >= n);
                nd  = ne ? 8'h00 : chan[sel];
                nc  = sel;
                if (scan) m_cnt[d] = (m_cnt[d] + 1) % n;
            end
            if (lat == 1) begin
                model_apply(d, nv, nd, nc, ne);
            end else begin
                model_apply(d, p_v[d], p_d[d], p_c[d], p_e[d]);
                p_v[d] = nv; p_d[d] = nd; p_c[d] = nc; p_e[d] = ne;
            end
        end
    endtask

    always @(posedge CLK) begin
        model_edge(0, 4, 1, 3);
        model_edge(1, 3, 2, 2);
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check_output("a_mo",       64'(if_a.MO),       64'(m_mo[0]));
            check_output("a_mo_valid", 64'(if_a.MO_VALID), 64'(m_v[0]));
            check_output("a_mo_ch",    64'(if_a.MO_CH),    64'(m_ch[0]));
            check_output("a_sel_err",  64'(if_a.SEL_ERR),  64'(m_err[0]));
            check_output("b_mo",       64'(if_b.MO),       64'(m_mo[1]));
            check_output("b_mo_valid", 64'(if_b.MO_VALID), 64'(m_v[1]));
            check_output("b_mo_ch",    64'(if_b.MO_CH),    64'(m_ch[1]));
            check_output("b_sel_err",  64'(if_b.SEL_ERR),  64'(m_err[1]));
        end
    end

    int qa_ch[$];
    int qb_ch[$];
    int qb_d[$];

    // One clock per call; valid outputs seen on enabled, non-reset edges are logged in order.
    task automatic apply_stimulus(input logic r, input logic e, input logic v,
                                  input logic [2:0] sv, input logic sc);
        sclr = r; ena = e; valid = v; s = sv; scan = sc;
        @(posedge CLK);
        @(negedge CLK);
        if (e && !r) begin
            if (if_a.MO_VALID) qa_ch.push_back(int'(if_a.MO_CH));
            if (if_b.MO_VALID) begin
                qb_ch.push_back(int'(if_b.MO_CH));
                qb_d.push_back(int'(if_b.MO));
            end
        end
    endtask

    task automatic clear_logs();
        qa_ch.delete();
        qb_ch.delete();
        qb_d.delete();
    endtask

    task automatic check_seq(input string name, input int got[$], input int exp[$]);
        check_output({name, "_len"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check_output(name, 64'(got[i]), 64'(exp[i]));
        end
    endtask

    initial begin
        int e_seq[$];
        chan[0] = 8'h11; chan[1] = 8'h22; chan[2] = 8'h33; chan[3] = 8'h44;

        // Reset and basic select.
        apply_stimulus(1, 1, 1, 3'd2, 0);
        chk_en = 1'b1;
        apply_stimulus(1, 1, 1, 3'd2, 0);
        check_output("rst_a_mo", 64'(if_a.MO), 64'h0);
        check_output("rst_a_valid", 64'(if_a.MO_VALID), 64'h0);
        check_output("rst_b_valid", 64'(if_b.MO_VALID), 64'h0);
        apply_stimulus(0, 1, 1, 3'd2, 0);
        check_output("basic_a_mo", 64'(if_a.MO), 64'h33);
        check_output("basic_a_ch", 64'(if_a.MO_CH), 64'd2);
        check_output("basic_a_valid", 64'(if_a.MO_VALID), 64'd1);
        check_output("basic_a_err", 64'(if_a.SEL_ERR), 64'd0);
        check_output("basic_b_valid", 64'(if_b.MO_VALID), 64'd0);

        // Out-of-range selects on both instances.
        apply_stimulus(0, 1, 1, 3'd5, 0);
        check_output("oor_a_mo", 64'(if_a.MO), 64'h0);
        check_output("oor_a_err", 64'(if_a.SEL_ERR), 64'd1);
        check_output("oor_a_ch", 64'(if_a.MO_CH), 64'd5);
        check_output("lat2_b_mo", 64'(if_b.MO), 64'h33);
        apply_stimulus(0, 1, 1, 3'd3, 0);
        check_output("a_ch3_mo", 64'(if_a.MO), 64'h44);
        apply_stimulus(0, 1, 1, 3'd1, 0);
        check_output("oor_b_mo", 64'(if_b.MO), 64'h0);
        check_output("oor_b_err", 64'(if_b.SEL_ERR), 64'd1);
        check_output("oor_b_ch", 64'(if_b.MO_CH), 64'd3);
        check_output("oor_b_valid", 64'(if_b.MO_VALID), 64'd1);
        apply_stimulus(0, 1, 1, 3'd1, 0);
        check_output("after_oor_b_err", 64'(if_b.SEL_ERR), 64'd0);
        check_output("after_oor_b_mo", 64'(if_b.MO), 64'h22);

        // Scan wrap.
        chan[0] = 8'hA0; chan[1] = 8'hA1; chan[2] = 8'hA2; chan[3] = 8'hA3;
        apply_stimulus(1, 1, 0, 3'd0, 0);
        clear_logs();
        for (int i = 0; i < 7; i++) apply_stimulus(0, 1, 1, 3'd0, 1);
        apply_stimulus(0, 1, 0, 3'd0, 1);
        apply_stimulus(0, 1, 0, 3'd0, 1);
        e_seq = {0, 1, 2, 3, 0, 1, 2};
        check_seq("scan_a_ch", qa_ch, e_seq);
        e_seq = {0, 1, 2, 0, 1, 2, 0};
        check_seq("scan_b_ch", qb_ch, e_seq);
        e_seq = {'hA0, 'hA1, 'hA2, 'hA0, 'hA1, 'hA2, 'hA0};
        check_seq("scan_b_data", qb_d, e_seq);

        // Stall and bubble.
        apply_stimulus(1, 1, 0, 3'd0, 0);
        clear_logs();
        apply_stimulus(0, 1, 1, 3'd0, 0);
        for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 1, 3'd1, 0);
        check_output("stall_a_mo", 64'(if_a.MO), 64'hA0);
        check_output("stall_a_valid", 64'(if_a.MO_VALID), 64'd1);
        check_output("stall_b_valid", 64'(if_b.MO_VALID), 64'd0);
        apply_stimulus(0, 1, 1, 3'd1, 0);
        apply_stimulus(0, 1, 0, 3'd1, 0);
        check_output("bubble_b_mo", 64'(if_b.MO), 64'hA1);
        check_output("bubble_b_valid", 64'(if_b.MO_VALID), 64'd1);
        apply_stimulus(0, 1, 0, 3'd1, 0);
        check_output("bubble_b_hold_mo", 64'(if_b.MO), 64'hA1);
        check_output("bubble_b_hold_valid", 64'(if_b.MO_VALID), 64'd0);
        e_seq = {'hA0, 'hA1};
        check_seq("stall_b_data", qb_d, e_seq);

        // Reset with samples in flight.
        apply_stimulus(1, 1, 0, 3'd0, 0);
        apply_stimulus(0, 1, 1, 3'd0, 1);
        apply_stimulus(0, 1, 1, 3'd0, 1);
        apply_stimulus(1, 1, 1, 3'd0, 1);
        check_output("midrst_b_valid", 64'(if_b.MO_VALID), 64'd0);
        check_output("midrst_b_mo", 64'(if_b.MO), 64'h0);
        apply_stimulus(0, 1, 1, 3'd0, 1);
        check_output("midrst_b_stage_valid", 64'(if_b.MO_VALID), 64'd0);
        apply_stimulus(0, 1, 0, 3'd0, 1);
        check_output("midrst_b_ch", 64'(if_b.MO_CH), 64'd0);
        check_output("midrst_b_valid2", 64'(if_b.MO_VALID), 64'd1);

        // Mode switch between scan and external select.
        apply_stimulus(1, 1, 0, 3'd0, 0);
        clear_logs();
        apply_stimulus(0, 1, 1, 3'd0, 1);
        apply_stimulus(0, 1, 1, 3'd0, 1);
        apply_stimulus(0, 1, 1, 3'd3, 0);
        apply_stimulus(0, 1, 1, 3'd0, 1);
        apply_stimulus(0, 1, 0, 3'd0, 1);
        apply_stimulus(0, 1, 0, 3'd0, 1);
        e_seq = {0, 1, 3, 2};
        check_seq("mode_a_ch", qa_ch, e_seq);
        check_seq("mode_b_ch", qb_ch, e_seq);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
